dcr_decode: RTL and testbench

//  Pipeline ID stage, directly downstream of the fetch stage. Consumes the IF/ID instruction and PC+1.

---
 rtl/dcr_decode.sv | 199 +++++++++++++++++++
 tb/tb_dcr_decode.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dcr_decode.sv
// dcr_decode -- pipeline ID stage.
//   Decodes the IF/ID instruction and reads the 32-entry register file. WB writes
//   are forwarded to the read ports in the same cycle. The stage detects load-use
//   hazards, which stall fetch and insert a bubble, and it resolves J and JR.
//   The decoded bundle is registered into the ID/EX register.
// Ports:
//   clk, rst (async, active high), clken (global enable)
//   InstructionInID / PCPlusOneInID        : from fetch IF/ID register
//   FlushInID                              : squash the instruction in ID
//   RegWriteInWB / WriteRegInWB / WriteDataInWB : WB write port
//   StallOutIF, JumpOutIF/JumpTargetOutIF, RegJumpOutIF/RegTargetOutIF : to fetch
//   *OutEX                                 : registered ID/EX bundle
module dcr_decode #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [31:0]       InstructionInID,
  input  logic [ADDR_W-1:0] PCPlusOneInID,
  input  logic              FlushInID,
  input  logic              RegWriteInWB,
  input  logic [4:0]        WriteRegInWB,
  input  logic [DATA_W-1:0] WriteDataInWB,
  output logic              StallOutIF,
  output logic              JumpOutIF,
  output logic [ADDR_W-1:0] JumpTargetOutIF,
  output logic              RegJumpOutIF,
  output logic [ADDR_W-1:0] RegTargetOutIF,
  output logic [DATA_W-1:0] ReadData1OutEX,
  output logic [DATA_W-1:0] ReadData2OutEX,
  output logic [DATA_W-1:0] ImmOutEX,
  output logic [4:0]        RsOutEX,
  output logic [4:0]        RtOutEX,
  output logic [4:0]        RdOutEX,
  output logic [5:0]        FunctOutEX,
  output logic [ADDR_W-1:0] PCPlusOneOutEX,
  output logic              RegWriteOutEX,
  output logic              MemReadOutEX,
  output logic              MemWriteOutEX,
  output logic              MemToRegOutEX,
  output logic              ALUSrcOutEX,
  output logic              RegDstOutEX,
  output logic              BranchOutEX,
  output logic [1:0]        ALUOpOutEX,
  output logic              IllegalOutEX
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t              ctl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] pc1;
  } idex_t;

  logic [DATA_W-1:0] r_regs [NREG];
  idex_t             r_idex;

  logic [5:0]        w_op, w_funct;
  logic [4:0]        w_rs, w_rt, w_rd;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_imm;
  logic              w_wb_vld, w_is_jr, w_rt_used, w_haz, w_bubble;
  ctl_t              w_ctl;
  idex_t             w_next;

  assign w_op    = InstructionInID[31:26];
  assign w_rs    = InstructionInID[25:21];
  assign w_rt    = InstructionInID[20:16];
  assign w_rd    = InstructionInID[15:11];
  assign w_funct = InstructionInID[5:0];
  assign w_imm   = {{(DATA_W-16){InstructionInID[15]}}, InstructionInID[15:0]};

  // Register file. r0 is never written and always reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (clken && RegWriteInWB && WriteRegInWB != 5'd0) begin
      r_regs[WriteRegInWB] <= WriteDataInWB;
    end
  end

  // Write-through: the WB value is visible to the reader in the same cycle.
  assign w_wb_vld = RegWriteInWB && (WriteRegInWB != 5'd0);
  assign w_rd1 = (w_rs == 5'd0) ? '0 :
                 (w_wb_vld && WriteRegInWB == w_rs) ? WriteDataInWB : r_regs[w_rs];
  assign w_rd2 = (w_rt == 5'd0) ? '0 :
                 (w_wb_vld && WriteRegInWB == w_rt) ? WriteDataInWB : r_regs[w_rt];

  assign w_is_jr = (w_op == OP_R) && (w_funct == FN_JR);

  always_comb begin
    w_ctl = '0;
    case (w_op)
      OP_R: begin
        w_ctl.reg_write = ~w_is_jr;
        w_ctl.reg_dst   = 1'b1;
        w_ctl.alu_op    = 2'b10;
      end
      OP_LW: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_read   = 1'b1;
        w_ctl.mem_to_reg = 1'b1;
        w_ctl.alu_src    = 1'b1;
      end
      OP_SW: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        w_ctl.branch = 1'b1;
        w_ctl.alu_op = 2'b01;
      end
      OP_ADDI: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.alu_src   = 1'b1;
      end
      OP_J: ;
      default: w_ctl.illegal = 1'b1;
    endcase
  end

  // rt is a true source operand only for R-type, SW and BEQ. For ADDI and LW
  // it is a destination, so a match there must not stall.
  assign w_rt_used = (w_op == OP_R) || (w_op == OP_SW) || (w_op == OP_BEQ);
  assign w_haz = r_idex.ctl.mem_read && (r_idex.rt != 5'd0) &&
                 ((r_idex.rt == w_rs) || ((r_idex.rt == w_rt) && w_rt_used));

  assign StallOutIF      = w_haz & ~FlushInID;
  assign JumpOutIF       = (w_op == OP_J) & ~StallOutIF & ~FlushInID;
  assign JumpTargetOutIF = InstructionInID[ADDR_W-1:0];
  assign RegJumpOutIF    = w_is_jr & ~StallOutIF & ~FlushInID;
  assign RegTargetOutIF  = w_rd1[ADDR_W-1:0];

  always_comb begin
    w_next.ctl   = w_ctl;
    w_next.rd1   = w_rd1;
    w_next.rd2   = w_rd2;
    w_next.imm   = w_imm;
    w_next.rs    = w_rs;
    w_next.rt    = w_rt;
    w_next.rd    = w_rd;
    w_next.funct = w_funct;
    w_next.pc1   = PCPlusOneInID;
  end

  // The bubble is the all-zero bundle. This bundle is also the reset state.
  assign w_bubble = FlushInID | StallOutIF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_idex <= '0;
    else if (clken)   r_idex <= w_bubble ? '0 : w_next;
  end

  assign ReadData1OutEX = r_idex.rd1;
  assign ReadData2OutEX = r_idex.rd2;
  assign ImmOutEX       = r_idex.imm;
  assign RsOutEX        = r_idex.rs;
  assign RtOutEX        = r_idex.rt;
  assign RdOutEX        = r_idex.rd;
  assign FunctOutEX     = r_idex.funct;
  assign PCPlusOneOutEX = r_idex.pc1;
  assign RegWriteOutEX  = r_idex.ctl.reg_write;
  assign MemReadOutEX   = r_idex.ctl.mem_read;
  assign MemWriteOutEX  = r_idex.ctl.mem_write;
  assign MemToRegOutEX  = r_idex.ctl.mem_to_reg;
  assign ALUSrcOutEX    = r_idex.ctl.alu_src;
  assign RegDstOutEX    = r_idex.ctl.reg_dst;
  assign BranchOutEX    = r_idex.ctl.branch;
  assign ALUOpOutEX     = r_idex.ctl.alu_op;
  assign IllegalOutEX   = r_idex.ctl.illegal;

endmodule

// File: tb/tb_dcr_decode.sv
// Testbench for dcr_decode.
//   Each table row describes one ID cycle. The bench checks the combinational
//   fetch-side outputs during that cycle and the ID/EX bundle after the edge.
//   Hand-written sequences then cover clken hold and reset mid-stall.
module tb_dcr_decode;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  // {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegDst,Branch,ALUOp[1:0],Illegal}
  localparam logic [9:0] C_BUB  = 10'b0_0_0_0_0_0_0_00_0;
  localparam logic [9:0] C_R    = 10'b1_0_0_0_0_1_0_10_0;
  localparam logic [9:0] C_JR   = 10'b0_0_0_0_0_1_0_10_0;
  localparam logic [9:0] C_LW   = 10'b1_1_0_1_1_0_0_00_0;
  localparam logic [9:0] C_SW   = 10'b0_0_1_0_1_0_0_00_0;
  localparam logic [9:0] C_BEQ  = 10'b0_0_0_0_0_0_1_01_0;
  localparam logic [9:0] C_ADDI = 10'b1_0_0_0_1_0_0_00_0;
  localparam logic [9:0] C_J    = 10'b0_0_0_0_0_0_0_00_0;
  localparam logic [9:0] C_ILL  = 10'b0_0_0_0_0_0_0_00_1;

  logic clk = 1'b0, rst = 1'b1, clken = 1'b1;
  logic [31:0] InstructionInID = '0;
  logic [ADDR_W-1:0] PCPlusOneInID = '0;
  logic FlushInID = 1'b0, RegWriteInWB = 1'b0;
  logic [4:0] WriteRegInWB = '0;
  logic [DATA_W-1:0] WriteDataInWB = '0;
  logic StallOutIF, JumpOutIF, RegJumpOutIF;
  logic [ADDR_W-1:0] JumpTargetOutIF, RegTargetOutIF, PCPlusOneOutEX;
  logic [DATA_W-1:0] ReadData1OutEX, ReadData2OutEX, ImmOutEX;
  logic [4:0] RsOutEX, RtOutEX, RdOutEX;
  logic [5:0] FunctOutEX;
  logic RegWriteOutEX, MemReadOutEX, MemWriteOutEX, MemToRegOutEX;
  logic ALUSrcOutEX, RegDstOutEX, BranchOutEX, IllegalOutEX;
  logic [1:0] ALUOpOutEX;

  dcr_decode #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(32)) dut (
    .clk(clk), .rst(rst), .clken(clken),
    .InstructionInID(InstructionInID), .PCPlusOneInID(PCPlusOneInID),
    .FlushInID(FlushInID), .RegWriteInWB(RegWriteInWB),
    .WriteRegInWB(WriteRegInWB), .WriteDataInWB(WriteDataInWB),
    .StallOutIF(StallOutIF), .JumpOutIF(JumpOutIF), .JumpTargetOutIF(JumpTargetOutIF),
    .RegJumpOutIF(RegJumpOutIF), .RegTargetOutIF(RegTargetOutIF),
    .ReadData1OutEX(ReadData1OutEX), .ReadData2OutEX(ReadData2OutEX),
    .ImmOutEX(ImmOutEX), .RsOutEX(RsOutEX), .RtOutEX(RtOutEX), .RdOutEX(RdOutEX),
    .FunctOutEX(FunctOutEX), .PCPlusOneOutEX(PCPlusOneOutEX),
    .RegWriteOutEX(RegWriteOutEX), .MemReadOutEX(MemReadOutEX),
    .MemWriteOutEX(MemWriteOutEX), .MemToRegOutEX(MemToRegOutEX),
    .ALUSrcOutEX(ALUSrcOutEX), .RegDstOutEX(RegDstOutEX), .BranchOutEX(BranchOutEX),
    .ALUOpOutEX(ALUOpOutEX), .IllegalOutEX(IllegalOutEX)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] ctl_now();
    return {RegWriteOutEX, MemReadOutEX, MemWriteOutEX, MemToRegOutEX, ALUSrcOutEX,
            RegDstOutEX, BranchOutEX, ALUOpOutEX, IllegalOutEX};
  endfunction

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic        fl, wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic        stall, jmp, rjmp;
    logic [7:0]  tgt;
    logic [9:0]  ctl;
    logic        dchk;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(string nm, logic [31:0] ins, logic fl, logic wbe,
                             logic [4:0] wbr, logic [31:0] wbd, logic stall,
                             logic jmp, logic rjmp, logic [7:0] tgt, logic [9:0] ctl,
                             logic dchk, logic [31:0] rd1, logic [31:0] rd2,
                             logic [31:0] imm, logic [4:0] rt);
    vec_t r;
    r.nm = nm; r.ins = ins; r.fl = fl; r.wbe = wbe; r.wbr = wbr; r.wbd = wbd;
    r.stall = stall; r.jmp = jmp; r.rjmp = rjmp; r.tgt = tgt; r.ctl = ctl;
    r.dchk = dchk; r.rd1 = rd1; r.rd2 = rd2; r.imm = imm; r.rt = rt;
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    //               name         instr        fl wbe wbr  wbd          st jp rj tgt    ctl     d rd1     rd2          imm          rt
    tv.push_back(v("addi_r1",   32'h20010005, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_ADDI, 1, 32'h0,   32'h0,       32'h5,       5'd1));
    tv.push_back(v("add_byp",   32'h00632020, 0, 1, 3,  32'hDEADBEEF, 0, 0, 0, 8'h0,  C_R,    1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h2020, 5'd3));
    tv.push_back(v("r0_wb",     32'h00033020, 0, 1, 0,  32'hFFFFFFFF, 0, 0, 0, 8'h0,  C_R,    1, 32'h0,   32'hDEADBEEF, 32'h3020,   5'd3));
    tv.push_back(v("r0_read",   32'h00003020, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_R,    1, 32'h0,   32'h0,       32'h3020,    5'd0));
    tv.push_back(v("nop_wb_r1", 32'h00000000, 0, 1, 1,  32'h5,        0, 0, 0, 8'h0,  C_R,    1, 32'h0,   32'h0,       32'h0,       5'd0));
    tv.push_back(v("lw_r2",     32'h8C220000, 0, 1, 7,  32'h123,      0, 0, 0, 8'h0,  C_LW,   1, 32'h5,   32'h0,       32'h0,       5'd2));
    tv.push_back(v("lu_stall",  32'h00412820, 0, 0, 0,  32'h0,        1, 0, 0, 8'h0,  C_BUB,  0, 32'h0,   32'h0,       32'h0,       5'd0));
    tv.push_back(v("lu_issue",  32'h00412820, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_R,    1, 32'h0,   32'h5,       32'h2820,    5'd1));
    tv.push_back(v("sw_plain",  32'hAC260004, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_SW,   1, 32'h5,   32'h0,       32'h4,       5'd6));
    tv.push_back(v("lw_r2_b",   32'h8C220000, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_LW,   1, 32'h5,   32'h0,       32'h0,       5'd2));
    tv.push_back(v("sw_nodep",  32'hAC260004, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_SW,   1, 32'h5,   32'h0,       32'h4,       5'd6));
    tv.push_back(v("lw_r2_c",   32'h8C220000, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_LW,   1, 32'h5,   32'h0,       32'h0,       5'd2));
    tv.push_back(v("flush_haz", 32'h00412820, 1, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_BUB,  0, 32'h0,   32'h0,       32'h0,       5'd0));
    tv.push_back(v("j_flush",   32'h08000040, 1, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_BUB,  0, 32'h0,   32'h0,       32'h0,       5'd0));
    tv.push_back(v("j_taken",   32'h08000040, 0, 0, 0,  32'h0,        0, 1, 0, 8'h40, C_J,    1, 32'h0,   32'h0,       32'h40,      5'd0));
    tv.push_back(v("jr_r7",     32'h00E00008, 0, 0, 0,  32'h0,        0, 0, 1, 8'h23, C_JR,   1, 32'h123, 32'h0,       32'h8,       5'd0));
    tv.push_back(v("illegal",   32'hFC000000, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_ILL,  1, 32'h0,   32'h0,       32'h0,       5'd0));
    tv.push_back(v("beq_neg",   32'h1027FFFF, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_BEQ,  1, 32'h5,   32'h123,     32'hFFFFFFFF, 5'd7));
    tv.push_back(v("lw_r7",     32'h8C270000, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_LW,   1, 32'h5,   32'h123,     32'h0,       5'd7));
    tv.push_back(v("beq_rt_st", 32'h1027FFFF, 0, 0, 0,  32'h0,        1, 0, 0, 8'h0,  C_BUB,  0, 32'h0,   32'h0,       32'h0,       5'd0));
    tv.push_back(v("beq_issue", 32'h1027FFFF, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_BEQ,  1, 32'h5,   32'h123,     32'hFFFFFFFF, 5'd7));
    tv.push_back(v("lw_r7_b",   32'h8C270000, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_LW,   1, 32'h5,   32'h123,     32'h0,       5'd7));
    tv.push_back(v("addi_rt_ok",32'h20270001, 0, 0, 0,  32'h0,        0, 0, 0, 8'h0,  C_ADDI, 1, 32'h5,   32'h123,     32'h1,       5'd7));

    // Reset state
    #12;
    chk("rst_ctl", {22'h0, ctl_now()}, 32'h0);
    chk("rst_stall", {31'h0, StallOutIF}, 32'h0);
    chk("rst_imm", ImmOutEX, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (tv[i]) begin
      InstructionInID = tv[i].ins;
      FlushInID       = tv[i].fl;
      RegWriteInWB    = tv[i].wbe;
      WriteRegInWB    = tv[i].wbr;
      WriteDataInWB   = tv[i].wbd;
      #1;
      chk({tv[i].nm, ".stall"}, {31'h0, StallOutIF}, {31'h0, tv[i].stall});
      chk({tv[i].nm, ".jmp"},   {31'h0, JumpOutIF},  {31'h0, tv[i].jmp});
      chk({tv[i].nm, ".rjmp"},  {31'h0, RegJumpOutIF}, {31'h0, tv[i].rjmp});
      if (tv[i].jmp)  chk({tv[i].nm, ".jtgt"}, {24'h0, JumpTargetOutIF}, {24'h0, tv[i].tgt});
      if (tv[i].rjmp) chk({tv[i].nm, ".rtgt"}, {24'h0, RegTargetOutIF}, {24'h0, tv[i].tgt});
      step();
      chk({tv[i].nm, ".ctl"}, {22'h0, ctl_now()}, {22'h0, tv[i].ctl});
      if (tv[i].dchk) begin
        chk({tv[i].nm, ".rd1"}, ReadData1OutEX, tv[i].rd1);
        chk({tv[i].nm, ".rd2"}, ReadData2OutEX, tv[i].rd2);
        chk({tv[i].nm, ".imm"}, ImmOutEX, tv[i].imm);
        chk({tv[i].nm, ".rt"},  {27'h0, RtOutEX}, {27'h0, tv[i].rt});
      end
    end
    FlushInID = 1'b0;

    // clken=0: the ID/EX bundle (ADDI r7,r1,1) and the regfile hold
    clken = 1'b0;
    InstructionInID = 32'h8C220000;
    RegWriteInWB = 1'b1; WriteRegInWB = 5'd1; WriteDataInWB = 32'h99;
    step();
    chk("hold.ctl", {22'h0, ctl_now()}, {22'h0, C_ADDI});
    chk("hold.imm", ImmOutEX, 32'h1);
    clken = 1'b1; RegWriteInWB = 1'b0;
    InstructionInID = 32'h00412820;   // ADD r5,r2,r1
    step();
    chk("hold.r1", ReadData2OutEX, 32'h5);

    // Reset asserted mid-stall
    InstructionInID = 32'h8C220000;   // LW r2,0(r1)
    step();
    InstructionInID = 32'h00412820;   // ADD r5,r2,r1 -> stall
    #1;
    chk("mid.stall", {31'h0, StallOutIF}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid.rst_stall", {31'h0, StallOutIF}, 32'h0);
    chk("mid.rst_ctl", {22'h0, ctl_now()}, 32'h0);
    chk("mid.rst_rt", {27'h0, RtOutEX}, 32'h0);
    #2 rst = 1'b0;
    step();
    chk("mid.after_ctl", {22'h0, ctl_now()}, {22'h0, C_R});
    chk("mid.r1_zero", ReadData2OutEX, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
